// File: rtl/warp_dispatcher_pkg.sv
// Shared definitions for the warp dispatcher and the issue stage that consumes its requests.
// Covers the request layout, the decoded-instruction field offsets and the "no register" index.
package warp_dispatcher_pkg;

   localparam int REQ_W       = 103;
   localparam int INSTR_W     = 63;
   localparam int REG_W       = 5;
   localparam int OPCODE_W    = 8;

   localparam int WARP_ID_MSB = 102;
   localparam int WARP_ID_LSB = 98;
   localparam int INSTR_MSB   = 97;
   localparam int INSTR_LSB   = 35;
   localparam int PC_MSB      = 34;
   localparam int PC_LSB      = 3;

   localparam int RD_LSB      = 58;
   localparam int RS1_LSB     = 53;
   localparam int RS2_LSB     = 48;
   localparam int OPCODE_LSB  = 40;

   localparam logic [REG_W-1:0] NO_REG = 5'd31;

   typedef struct packed {
      logic [4:0]         warp_id;
      logic [INSTR_W-1:0] instr;
      logic [31:0]        pc;
      logic [2:0]         pad;
   } dispatch_req_t;

   function automatic logic [REG_W-1:0] instr_rd(input logic [INSTR_W-1:0] instr);
      return instr[RD_LSB +: REG_W];
   endfunction

   function automatic logic [REG_W-1:0] instr_rs1(input logic [INSTR_W-1:0] instr);
      return instr[RS1_LSB +: REG_W];
   endfunction

   function automatic logic [REG_W-1:0] instr_rs2(input logic [INSTR_W-1:0] instr);
      return instr[RS2_LSB +: REG_W];
   endfunction

endpackage

// File: rtl/warp_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter: grants the lowest requester strictly after ptr,
// wrapping modulo N. The caller decides when ptr advances.
module warp_dispatcher_rr_arbiter #(
   parameter int N = 32
) (
   input  logic [N-1:0] req,
   input  logic [4:0]   ptr,
   output logic [N-1:0] grant,
   output logic [4:0]   grant_idx,
   output logic         grant_valid
);

   int idx;

   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      idx         = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!grant_valid && req[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = 5'(idx);
            grant[idx]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/warp_dispatcher.sv
// Per-warp instruction buffer plus register scoreboard; picks one hazard-free warp per cycle
// round-robin and offers it to the issue stage through a registered valid/ready output.
module warp_dispatcher
   import warp_dispatcher_pkg::*;
#(
   parameter int NUM_WARPS = 32,
   parameter int NUM_REGS  = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 fetch_valid,
   input  logic [4:0]           fetch_warp_id,
   input  logic [INSTR_W-1:0]   fetch_instr,
   input  logic [31:0]          fetch_pc,
   output logic                 fetch_ready,
   output logic [NUM_WARPS-1:0] ibuf_valid,
   input  logic [NUM_WARPS-1:0] warp_enable,
   input  logic                 wb_valid,
   input  logic [4:0]           wb_warp_id,
   input  logic [4:0]           wb_rd,
   output logic                 m_tvalid_request,
   input  logic                 m_tready_issue_fifo,
   output logic [REQ_W-1:0]     dispatch_request,
   output logic                 err
);

   logic [INSTR_W-1:0]  ibuf_instr [NUM_WARPS];
   logic [31:0]         ibuf_pc    [NUM_WARPS];
   logic [NUM_REGS-1:0] sb         [NUM_WARPS];

   logic [NUM_WARPS-1:0] eligible;
   logic [NUM_WARPS-1:0] grant;
   logic [NUM_WARPS-1:0] fetch_set;
   logic [4:0]           grant_idx;
   logic                 grant_valid;
   logic [4:0]           ptr;
   logic [REG_W-1:0]     sel_rd;
   logic                 load;
   logic                 fetch_accept;
   logic                 fetch_in_range;
   logic                 wb_en;
   logic                 wb_hit;
   dispatch_req_t        req_q;

   function automatic logic operand_busy(input logic [NUM_REGS-1:0] bits, input logic [REG_W-1:0] r);
      return (r != NO_REG) && bits[r];
   endfunction

   // Hazard check uses the registered scoreboard only; a writeback frees its warp one cycle later.
   always_comb begin
      eligible = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         eligible[w] = ibuf_valid[w] & warp_enable[w]
                     & ~operand_busy(sb[w], instr_rd(ibuf_instr[w]))
                     & ~operand_busy(sb[w], instr_rs1(ibuf_instr[w]))
                     & ~operand_busy(sb[w], instr_rs2(ibuf_instr[w]));
      end
   end

   warp_dispatcher_rr_arbiter #(.N(NUM_WARPS)) u_arb (
      .req         (eligible),
      .ptr         (ptr),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // Handshake: a request transfers on a clk edge where m_tvalid_request & m_tready_issue_fifo;
   // while valid is high and ready low the payload is frozen, and valid never drops without a transfer.
   assign load           = (~m_tvalid_request | m_tready_issue_fifo) & grant_valid;
   assign fetch_in_range = int'(fetch_warp_id) < NUM_WARPS;
   assign fetch_ready    = fetch_in_range & ~ibuf_valid[fetch_warp_id];
   assign fetch_accept   = fetch_valid & fetch_ready;
   assign sel_rd         = instr_rd(ibuf_instr[grant_idx]);
   assign wb_en          = wb_valid & (wb_rd != NO_REG) & (int'(wb_warp_id) < NUM_WARPS);
   assign wb_hit         = sb[wb_warp_id][wb_rd];
   assign dispatch_request = req_q;

   always_comb begin
      fetch_set = '0;
      if (fetch_accept) fetch_set[fetch_warp_id] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (fetch_accept) begin
         ibuf_instr[fetch_warp_id] <= fetch_instr;
         ibuf_pc[fetch_warp_id]    <= fetch_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ibuf_valid       <= '0;
         for (int w = 0; w < NUM_WARPS; w++) sb[w] <= '0;
         req_q            <= '0;
         m_tvalid_request <= 1'b0;
         err              <= 1'b0;
         ptr              <= 5'(NUM_WARPS - 1);
      end else begin
         ibuf_valid <= (ibuf_valid & ~(grant & {NUM_WARPS{load}})) | fetch_set;

         if (fetch_valid && !fetch_ready) err <= 1'b1;

         // A set rd blocks eligibility, so the clear and the set below never target the same bit.
         if (wb_en) begin
            if (wb_hit) sb[wb_warp_id][wb_rd] <= 1'b0;
            else        err <= 1'b1;
         end
         if (load && sel_rd != NO_REG) sb[grant_idx][sel_rd] <= 1'b1;

         if (load) begin
            req_q.warp_id    <= grant_idx;
            req_q.instr      <= ibuf_instr[grant_idx];
            req_q.pc         <= ibuf_pc[grant_idx];
            req_q.pad        <= 3'b000;
            m_tvalid_request <= 1'b1;
            ptr              <= grant_idx;
         end else if (m_tready_issue_fifo) begin
            m_tvalid_request <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_warp_dispatcher.sv
// Directed walk through the dispatcher's main scenarios followed by a randomized run,
// with a cycle-level behavioural model and a queue of expected dispatches.
module tb_warp_dispatcher;
   import warp_dispatcher_pkg::*;

   localparam int NW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          fetch_valid = 1'b0;
   logic [4:0]    fetch_warp_id = '0;
   logic [62:0]   fetch_instr = '0;
   logic [31:0]   fetch_pc = '0;
   logic          fetch_ready;
   logic [NW-1:0] ibuf_valid;
   logic [NW-1:0] warp_enable = '1;
   logic          wb_valid = 1'b0;
   logic [4:0]    wb_warp_id = '0;
   logic [4:0]    wb_rd = '0;
   logic          m_tvalid_request;
   logic          m_tready_issue_fifo = 1'b0;
   logic [102:0]  dispatch_request;
   logic          err;

   int checks = 0;
   int errors = 0;
   logic [102:0] exp_q[$];

   logic [NW-1:0] m_buf;
   logic [62:0]   m_instr [NW];
   logic [31:0]   m_pc [NW];
   bit            pend [NW][32];
   logic          m_valid;
   logic [102:0]  m_req;
   logic          m_err;
   int            m_last;

   warp_dispatcher dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .fetch_valid         (fetch_valid),
      .fetch_warp_id       (fetch_warp_id),
      .fetch_instr         (fetch_instr),
      .fetch_pc            (fetch_pc),
      .fetch_ready         (fetch_ready),
      .ibuf_valid          (ibuf_valid),
      .warp_enable         (warp_enable),
      .wb_valid            (wb_valid),
      .wb_warp_id          (wb_warp_id),
      .wb_rd               (wb_rd),
      .m_tvalid_request    (m_tvalid_request),
      .m_tready_issue_fifo (m_tready_issue_fifo),
      .dispatch_request    (dispatch_request),
      .err                 (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [62:0] mk_instr(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic [7:0] op);
      logic [62:0] i;
      i = '0;
      i[62:58] = rd;
      i[57:53] = rs1;
      i[52:48] = rs2;
      i[47:40] = op;
      return i;
   endfunction

   task automatic model_reset();
      m_buf   = '0;
      m_valid = 1'b0;
      m_req   = '0;
      m_err   = 1'b0;
      m_last  = NW - 1;
      for (int w = 0; w < NW; w++)
         for (int r = 0; r < 32; r++) pend[w][r] = 1'b0;
      exp_q.delete();
   endtask

   function automatic bit model_eligible(input int w);
      logic [4:0] regs [3];
      if (!m_buf[w] || !warp_enable[w]) return 1'b0;
      regs[0] = m_instr[w][62:58];
      regs[1] = m_instr[w][57:53];
      regs[2] = m_instr[w][52:48];
      for (int k = 0; k < 3; k++)
         if (regs[k] != 5'd31 && pend[w][regs[k]]) return 1'b0;
      return 1'b1;
   endfunction

   // One clock: compare against the model at negedge, advance the model, return at posedge+1.
   task automatic tick();
      int sel;
      int w;
      bit load;
      bit hs;
      bit fetch_ok;
      logic [4:0] rd;
      @(negedge clk);
      check("tvalid", m_tvalid_request, m_valid);
      check("request", dispatch_request, m_req);
      check("err", err, m_err);
      check("ibuf_valid", ibuf_valid, m_buf);
      check("fetch_ready", fetch_ready, !m_buf[fetch_warp_id]);
      sel = -1;
      for (int k = 1; k <= NW; k++) begin
         w = (m_last + k) % NW;
         if (sel < 0 && model_eligible(w)) sel = w;
      end
      hs       = m_valid && m_tready_issue_fifo;
      load     = (!m_valid || m_tready_issue_fifo) && sel >= 0;
      fetch_ok = fetch_valid && !m_buf[fetch_warp_id];
      if (hs) begin
         check("hs_queue_nonempty", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) check("hs_payload", dispatch_request, exp_q.pop_front());
      end
      if (fetch_valid && !fetch_ok) m_err = 1'b1;
      if (wb_valid && wb_rd != 5'd31) begin
         if (pend[wb_warp_id][wb_rd]) pend[wb_warp_id][wb_rd] = 1'b0;
         else                         m_err = 1'b1;
      end
      if (load) begin
         rd = m_instr[sel][62:58];
         if (rd != 5'd31) pend[sel][rd] = 1'b1;
         m_req    = {5'(sel), m_instr[sel], m_pc[sel], 3'b000};
         m_valid  = 1'b1;
         m_last   = sel;
         m_buf[sel] = 1'b0;
         exp_q.push_back(m_req);
      end else if (hs) begin
         m_valid = 1'b0;
      end
      if (fetch_ok) begin
         m_buf[fetch_warp_id]   = 1'b1;
         m_instr[fetch_warp_id] = fetch_instr;
         m_pc[fetch_warp_id]    = fetch_pc;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic drive_fetch(input logic [4:0] w, input logic [62:0] instr, input logic [31:0] pc);
      fetch_valid   = 1'b1;
      fetch_warp_id = w;
      fetch_instr   = instr;
      fetch_pc      = pc;
      tick();
      fetch_valid = 1'b0;
   endtask

   task automatic drive_wb(input logic [4:0] w, input logic [4:0] r);
      wb_valid   = 1'b1;
      wb_warp_id = w;
      wb_rd      = r;
      tick();
      wb_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic logic [4:0] rand_reg();
      int v;
      v = $urandom_range(0, 9);
      return (v >= 8) ? 5'd31 : 5'(v);
   endfunction

   initial begin
      logic [62:0]  instr_a;
      logic [102:0] held;
      int           pw[$];
      int           pr[$];
      int           pick;

      do_reset();
      check("rst_tvalid", m_tvalid_request, 1'b0);
      check("rst_request", dispatch_request, 103'd0);
      check("rst_err", err, 1'b0);
      check("rst_ibuf", ibuf_valid, 32'd0);

      // Basic fetch-to-dispatch latency
      warp_enable = '1;
      m_tready_issue_fifo = 1'b1;
      drive_fetch(5'd3, mk_instr(5'd5, 5'd1, 5'd2, 8'h11), 32'h100);
      check("t1_ibuf3", ibuf_valid[3], 1'b1);
      check("t1_tvalid_n1", m_tvalid_request, 1'b0);
      idle(1);
      check("t1_tvalid_n2", m_tvalid_request, 1'b1);
      check("t1_warp", dispatch_request[102:98], 5'd3);
      check("t1_pc", dispatch_request[34:3], 32'h100);
      check("t1_fetch_ready", fetch_ready, 1'b1);

      // RAW hazard released by writeback
      drive_fetch(5'd3, mk_instr(5'd6, 5'd5, 5'd31, 8'h22), 32'h104);
      idle(3);
      check("t2_blocked", m_tvalid_request, 1'b0);
      drive_wb(5'd3, 5'd5);
      check("t2_wb_cycle", m_tvalid_request, 1'b0);
      idle(1);
      check("t2_released", m_tvalid_request, 1'b1);
      check("t2_pc", dispatch_request[34:3], 32'h104);
      drive_wb(5'd3, 5'd6);
      check("t2_err", err, 1'b0);

      // Round-robin order with refill
      warp_enable[2:0] = 3'b000;
      drive_fetch(5'd0, mk_instr(5'd31, 5'd31, 5'd31, 8'h30), 32'h200);
      drive_fetch(5'd1, mk_instr(5'd31, 5'd31, 5'd31, 8'h31), 32'h204);
      drive_fetch(5'd2, mk_instr(5'd31, 5'd31, 5'd31, 8'h32), 32'h208);
      warp_enable = '1;
      idle(1);
      check("t3_grant0", dispatch_request[102:98], 5'd0);
      drive_fetch(5'd0, mk_instr(5'd31, 5'd31, 5'd31, 8'h33), 32'h20c);
      check("t3_grant1", dispatch_request[102:98], 5'd1);
      idle(1);
      check("t3_grant2", dispatch_request[102:98], 5'd2);
      idle(1);
      check("t3_grant0_again", dispatch_request[102:98], 5'd0);
      check("t3_pc_refill", dispatch_request[34:3], 32'h20c);
      idle(1);
      check("t3_drained", m_tvalid_request, 1'b0);

      // Back-pressure holds the payload
      m_tready_issue_fifo = 1'b0;
      warp_enable[4] = 1'b0;
      warp_enable[7] = 1'b0;
      drive_fetch(5'd4, mk_instr(5'd31, 5'd31, 5'd31, 8'h40), 32'h300);
      drive_fetch(5'd7, mk_instr(5'd31, 5'd31, 5'd31, 8'h47), 32'h304);
      warp_enable = '1;
      idle(1);
      check("t4_first", dispatch_request[102:98], 5'd4);
      held = dispatch_request;
      for (int i = 0; i < 5; i++) begin
         idle(1);
         check("t4_hold_valid", m_tvalid_request, 1'b1);
         check("t4_hold_payload", dispatch_request, held);
      end
      m_tready_issue_fifo = 1'b1;
      idle(1);
      check("t4_second", dispatch_request[102:98], 5'd7);
      idle(1);
      check("t4_done", m_tvalid_request, 1'b0);

      // Fetch into a full buffer, and a clear of an idle scoreboard bit
      warp_enable[2] = 1'b0;
      instr_a = mk_instr(5'd12, 5'd13, 5'd14, 8'h5a);
      drive_fetch(5'd2, instr_a, 32'h400);
      check("t5_err_before", err, 1'b0);
      drive_fetch(5'd2, mk_instr(5'd20, 5'd21, 5'd22, 8'ha5), 32'h500);
      check("t5_err_overflow", err, 1'b1);
      warp_enable = '1;
      idle(1);
      check("t5_instr_kept", dispatch_request[97:35], instr_a);
      check("t5_pc_kept", dispatch_request[34:3], 32'h400);
      do_reset();
      drive_wb(5'd0, 5'd9);
      check("t5_err_wb", err, 1'b1);
      do_reset();

      // No-register instruction gated by warp_enable, then reset mid-handshake
      m_tready_issue_fifo = 1'b1;
      warp_enable[6] = 1'b0;
      drive_fetch(5'd6, mk_instr(5'd31, 5'd31, 5'd31, 8'h66), 32'h600);
      idle(3);
      check("t6_disabled", m_tvalid_request, 1'b0);
      warp_enable = '1;
      idle(1);
      check("t6_enabled", m_tvalid_request, 1'b1);
      check("t6_warp", dispatch_request[102:98], 5'd6);
      m_tready_issue_fifo = 1'b0;
      warp_enable[5] = 1'b0;
      drive_fetch(5'd5, mk_instr(5'd8, 5'd31, 5'd31, 8'h55), 32'h700);
      drive_wb(5'd0, 5'd9);
      check("t6_err_set", err, 1'b1);
      check("t6_pending", m_tvalid_request, 1'b1);
      rst_n = 1'b0;
      #2;
      check("t6_rst_tvalid", m_tvalid_request, 1'b0);
      check("t6_rst_request", dispatch_request, 103'd0);
      check("t6_rst_err", err, 1'b0);
      check("t6_rst_ibuf", ibuf_valid, 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      warp_enable = '1;

      // Randomized traffic against the model
      for (int c = 0; c < 800; c++) begin
         fetch_valid   = ($urandom_range(0, 99) < 60);
         fetch_warp_id = 5'($urandom_range(0, 7));
         fetch_instr   = mk_instr(rand_reg(), rand_reg(), rand_reg(), 8'($urandom));
         fetch_pc      = $urandom;
         m_tready_issue_fifo = ($urandom_range(0, 99) < 70);
         for (int w = 0; w < 8; w++) warp_enable[w] = ($urandom_range(0, 9) != 0);
         pw.delete();
         pr.delete();
         for (int w = 0; w < 8; w++)
            for (int r = 0; r < 31; r++)
               if (pend[w][r]) begin
                  pw.push_back(w);
                  pr.push_back(r);
               end
         wb_valid = 1'b0;
         if (pw.size() != 0 && $urandom_range(0, 99) < 50) begin
            pick       = $urandom_range(0, pw.size() - 1);
            wb_valid   = 1'b1;
            wb_warp_id = 5'(pw[pick]);
            wb_rd      = 5'(pr[pick]);
         end else if ($urandom_range(0, 99) < 3) begin
            wb_valid   = 1'b1;
            wb_warp_id = 5'($urandom_range(0, 7));
            wb_rd      = 5'($urandom_range(0, 31));
         end
         tick();
      end
      fetch_valid = 1'b0;
      wb_valid    = 1'b0;
      m_tready_issue_fifo = 1'b1;
      idle(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
